// File: rtl/round_timer_tick_rx.sv
// round_timer_tick_rx: synchronises the 1 Hz divider toggle into the system
// clock domain and turns each rising edge into a one-cycle tick. The ticks
// drive the game round countdown.
// The optional warn blink output is enabled by defining ROUND_TIMER_WARN_EN.
module round_timer_tick_rx #(
    parameter int unsigned SEC_W       = 7,
    parameter int unsigned MAX_SECS    = 99,
    parameter int unsigned SYNC_STAGES = 2
`ifdef ROUND_TIMER_WARN_EN
    ,
    parameter int unsigned WARN_SECS   = 5
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic             start,
    input  logic             pause,
    input  logic [SEC_W-1:0] load_secs,
    output logic             tick,
    output logic [SEC_W-1:0] secs_left,
    output logic [3:0]       secs_tens,
    output logic [3:0]       secs_ones,
    output logic             running,
    output logic             done,
    output logic             expired
`ifdef ROUND_TIMER_WARN_EN
    ,
    output logic             warn
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [SEC_W-1:0] MAX_V = SEC_W'(MAX_SECS);
    localparam logic [SEC_W-1:0] ONE_V = SEC_W'(1);
    localparam logic [SEC_W-1:0] TEN_V = SEC_W'(10);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   tick_q, tick_d;
    state_e                 state_q, state_d;
    logic [SEC_W-1:0]       secs_q, secs_d;
    logic                   running_q, running_d;
    logic                   done_q, done_d;
    logic                   expired_q, expired_d;
    logic [SEC_W-1:0]       load_clamped;

    // Synchroniser shift, edge history and rising-edge detection
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], slow_clk};
        hist_d = sync_q[SYNC_STAGES-1];
        tick_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    // Round FSM next state, countdown value and status flags
    always_comb begin
        state_d      = state_q;
        secs_d       = secs_q;
        done_d       = 1'b0;
        load_clamped = (load_secs > MAX_V) ? MAX_V : load_secs;
        if (start) begin
            // start wins over tick and pause; a coincident tick is dropped
            secs_d = load_clamped;
            if (load_clamped == '0) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_IDLE: secs_d = '0;
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick_q) begin
                        if (secs_q <= ONE_V) begin
                            secs_d  = '0;
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            secs_d = secs_q - ONE_V;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause) state_d = ST_RUN;
                end
                ST_DONE: secs_d = '0;
                default: state_d = ST_IDLE;
            endcase
        end
        running_d = (state_d == ST_RUN);
        expired_d = (state_d == ST_DONE);
    end

`ifdef ROUND_TIMER_WARN_EN
    localparam logic [SEC_W-1:0] WARN_V = SEC_W'(WARN_SECS);
    logic warn_q, warn_d;

    // Warning blink: toggles on each counted tick inside the warning window
    always_comb begin
        warn_d = warn_q;
        if (start || state_d == ST_IDLE || state_d == ST_DONE) begin
            warn_d = 1'b0;
        end else if (state_q == ST_RUN && !pause && tick_q &&
                     secs_q != '0 && secs_q <= WARN_V) begin
            warn_d = ~warn_q;
        end
    end

    // Warning flag register
    always_ff @(posedge clock) begin
        if (reset) warn_q <= 1'b0;
        else       warn_q <= warn_d;
    end

    assign warn = warn_q;
`endif

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q    <= '0;
            hist_q    <= 1'b0;
            tick_q    <= 1'b0;
            state_q   <= ST_IDLE;
            secs_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            tick_q    <= tick_d;
            state_q   <= state_d;
            secs_q    <= secs_d;
            running_q <= running_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    assign tick      = tick_q;
    assign secs_left = secs_q;
    assign running   = running_q;
    assign done      = done_q;
    assign expired   = expired_q;
    assign secs_tens = 4'(secs_q / TEN_V);
    assign secs_ones = 4'(secs_q % TEN_V);

endmodule

// File: tb/tb_round_timer_tick_rx.sv
// Bench for round_timer_tick_rx: directed stimulus, an edge-queue / countdown
// reference model compared every cycle, plus hand-computed literal checks.
module tb_round_timer_tick_rx;

    localparam int unsigned SEC_W = 7;
    localparam int WARN = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             slow_clk = 1'b0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic [SEC_W-1:0] load_secs = '0;
    logic             tick;
    logic [SEC_W-1:0] secs_left;
    logic [3:0]       secs_tens;
    logic [3:0]       secs_ones;
    logic             running;
    logic             done;
    logic             expired;
`ifdef ROUND_TIMER_WARN_EN
    logic             warn;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    round_timer_tick_rx dut (
        .clock     (clock),
        .reset     (reset),
        .slow_clk  (slow_clk),
        .start     (start),
        .pause     (pause),
        .load_secs (load_secs),
        .tick      (tick),
        .secs_left (secs_left),
        .secs_tens (secs_tens),
        .secs_ones (secs_ones),
        .running   (running),
        .done      (done),
        .expired   (expired)
`ifdef ROUND_TIMER_WARN_EN
        ,
        .warn      (warn)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // slow_clk source: manual level, or free-running toggle every 20 cycles
    logic slow_man = 1'b0;
    logic slow_auto = 1'b0;
    logic slow_tog = 1'b0;
    int   scnt = 0;
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (slow_auto) begin
                scnt++;
                if (scnt >= 20) begin
                    scnt = 0;
                    slow_tog = ~slow_tog;
                end
            end
            slow_clk = slow_auto ? slow_tog : slow_man;
        end
    end

    // Reference model: a rising sample at edge n yields a tick after edge n+2;
    // the countdown follows the round rules using the tick visible before the edge.
    int cyc = 0;
    int q_tick[$];
    bit m_prev = 0;
    bit m_tick = 0;
    int m_secs = 0;
    int m_mode = 0;      // 0 idle, 1 running, 2 paused, 3 expired
    bit m_done = 0;
    bit m_warn = 0;
    bit model_live = 0;
    bit t_now;

    always @(posedge clock) begin
        t_now = m_tick;
        cyc++;
        if (reset) begin
            q_tick.delete();
            m_prev = 0; m_tick = 0; m_secs = 0; m_mode = 0; m_done = 0; m_warn = 0;
        end else begin
            if (slow_clk && !m_prev) q_tick.push_back(cyc + 2);
            m_prev = slow_clk;
            m_tick = (q_tick.size() > 0 && q_tick[0] == cyc);
            if (m_tick) void'(q_tick.pop_front());
            m_done = 0;
            if (start) begin
                m_secs = (int'(load_secs) > 99) ? 99 : int'(load_secs);
                m_mode = (m_secs == 0) ? 3 : 1;
                m_done = (m_secs == 0);
                m_warn = 0;
            end else if (m_mode == 1) begin
                if (pause) m_mode = 2;
                else if (t_now && m_secs > 0) begin
                    if (m_secs <= WARN) m_warn = !m_warn;
                    m_secs = m_secs - 1;
                    if (m_secs == 0) begin
                        m_mode = 3; m_done = 1; m_warn = 0;
                    end
                end
            end else if (m_mode == 2) begin
                if (!pause) m_mode = 1;
            end
        end
        model_live = 1;
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (model_live) begin
            chk("m_tick",    tick,      m_tick);
            chk("m_secs",    secs_left, m_secs);
            chk("m_tens",    secs_tens, m_secs / 10);
            chk("m_ones",    secs_ones, m_secs % 10);
            chk("m_running", running,   m_mode == 1);
            chk("m_done",    done,      m_done);
            chk("m_expired", expired,   m_mode == 3);
`ifdef ROUND_TIMER_WARN_EN
            chk("m_warn",    warn,      m_warn);
`endif
        end
    end

    task automatic wait_tick(input string name, input int maxc);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (tick !== 1'b1 && k < maxc);
        if (tick !== 1'b1) chk(name, tick, 1);
    endtask

    initial begin
        int n;
        int tcount;
        int dcount;
        int seq[$];
        bit saw_run;

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        chk("rst_tick", tick, 0);
        chk("rst_secs", secs_left, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_expired", expired, 0);
        reset = 1'b0;

        // Tick latency: sampling edge counts as first, tick after the third
        step();
        slow_man = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 10);
        chk("tick_latency", n, 3);
        step();
        chk("tick_one_cycle", tick, 0);
        slow_man = 1'b0;
        tcount = 0;
        repeat (8) begin
            step();
            if (tick === 1'b1) tcount++;
        end
        chk("no_tick_on_fall", tcount, 0);

        // Free-running slow clock: five rising edges in the window
        slow_auto = 1'b1;
        tcount = 0;
        repeat (200) begin
            step();
            if (tick === 1'b1) tcount++;
        end
        chk("idle_tick_count", tcount, 5);
        chk("idle_running", running, 0);
        chk("idle_secs", secs_left, 0);

        // Short round 3 -> 0
        load_secs = 7'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("r3_secs", secs_left, 3);
        chk("r3_tens", secs_tens, 0);
        chk("r3_ones", secs_ones, 3);
        chk("r3_running", running, 1);
        seq.delete();
        seq.push_back(int'(secs_left));
        dcount = 0;
        n = 0;
        while (expired !== 1'b1 && n < 300) begin
            step();
            n++;
            if (done === 1'b1) dcount++;
            if (int'(secs_left) != seq[$]) seq.push_back(int'(secs_left));
        end
        repeat (5) begin
            step();
            if (done === 1'b1) dcount++;
        end
        chk("r3_seq_len", seq.size(), 4);
        if (seq.size() == 4) begin
            chk("r3_seq1", seq[1], 2);
            chk("r3_seq2", seq[2], 1);
            chk("r3_seq3", seq[3], 0);
        end
        chk("r3_done_count", dcount, 1);
        chk("r3_expired", expired, 1);
        chk("r3_running_end", running, 0);

        // Pause across two ticks, then resume for one tick
        load_secs = 7'd10;
        start = 1'b1;
        pause = 1'b1;
        step();
        start = 1'b0;
        wait_tick("pause_wait1", 100);
        wait_tick("pause_wait2", 100);
        step();
        chk("pause_secs_hold", secs_left, 10);
        chk("pause_running", running, 0);
        pause = 1'b0;
        wait_tick("resume_wait", 100);
        step();
        chk("resume_secs", secs_left, 9);
        chk("resume_tens", secs_tens, 0);
        chk("resume_ones", secs_ones, 9);
        chk("resume_running", running, 1);

        // Clamp and zero load
        load_secs = 7'd120;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("clamp_secs", secs_left, 99);
        chk("clamp_tens", secs_tens, 9);
        chk("clamp_ones", secs_ones, 9);
        load_secs = 7'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_expired", expired, 1);
        saw_run = (running === 1'b1);
        dcount = 0;
        repeat (4) begin
            step();
            if (running === 1'b1) saw_run = 1'b1;
            if (done === 1'b1) dcount++;
        end
        chk("zero_no_run", saw_run, 0);
        chk("zero_done_once", dcount, 0);

        // Start coincident with a tick: tick discarded
        load_secs = 7'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_tick("coinc_wait", 100);
        chk("coinc_pre_secs", secs_left, 5);
        load_secs = 7'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("coinc_secs", secs_left, 7);
        chk("coinc_running", running, 1);
        step();
        chk("coinc_secs_hold", secs_left, 7);

        // Reset mid-round at 4 seconds
        n = 0;
        while (secs_left !== 7'd4 && n < 300) begin
            step();
            n++;
        end
        chk("mid_reach4", secs_left, 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_secs", secs_left, 0);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_expired", expired, 0);
        chk("mid_rst_tick", tick, 0);
        repeat (120) step();
        chk("post_rst_secs", secs_left, 0);
        chk("post_rst_running", running, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
